// File: rtl/cacheline_adapter.sv
// cacheline_adapter
// Bridges the cache's single-beat 256-bit line port to a 64-bit burst memory.
// Each line read or write from the cache becomes a 4-beat burst; the cache
// gets a one-cycle resp_o when the whole line has been moved.
//
// Ports
//   clk, rst     clock and synchronous active-high reset
//   address_i    line request address from the cache
//   line_i       line write data from the cache
//   line_o       assembled line read data to the cache
//   read_i       line read request
//   write_i      line write request
//   resp_o       one-cycle completion pulse to the cache
//   address_o    line-aligned burst address to memory
//   burst_i      read beat data from memory
//   burst_o      write beat data to memory
//   read_o       burst read request
//   write_o      burst write request
//   resp_i       per-beat acknowledge from memory
module cacheline_adapter #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_burst  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         address_i,
  input  logic [s_line-1:0]   line_i,
  output logic [s_line-1:0]   line_o,
  input  logic                read_i,
  input  logic                write_i,
  output logic                resp_o,
  output logic [31:0]         address_o,
  input  logic [s_burst-1:0]  burst_i,
  output logic [s_burst-1:0]  burst_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i
);

  localparam int beats = s_line / s_burst;
  localparam int cw    = $clog2(beats);
  localparam logic [cw-1:0] last_beat = cw'(beats - 1);
  // Clears the byte-offset bits so the burst always starts on a line boundary.
  localparam logic [31:0] addr_mask = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t             state;
  logic [cw-1:0]      count;
  logic [s_line-1:0]  rd_buf;
  logic [s_line-1:0]  wr_line;

  // Single FSM: all outputs are registered. The beat counter only advances on
  // resp_i, so memory may insert any number of idle cycles between beats.
  // On the final read beat the line is assembled from the buffered lower beats
  // plus the beat arriving this cycle, so line_o is valid together with resp_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      rd_buf    <= '0;
      wr_line   <= '0;
      line_o    <= '0;
      address_o <= '0;
      burst_o   <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_o <= 1'b0;
          count  <= '0;
          // Read has priority when both requests are raised together.
          if (read_i) begin
            address_o <= address_i & addr_mask;
            read_o    <= 1'b1;
            state     <= READ;
          end else if (write_i) begin
            address_o <= address_i & addr_mask;
            wr_line   <= line_i;
            burst_o   <= line_i[s_burst-1:0];
            write_o   <= 1'b1;
            state     <= WRITE;
          end
        end

        READ: begin
          if (resp_i) begin
            rd_buf[count * s_burst +: s_burst] <= burst_i;
            if (count == last_beat) begin
              line_o <= {burst_i, rd_buf[s_line-s_burst-1:0]};
              count  <= '0;
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= DONE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end

        WRITE: begin
          // burst_o is preloaded with the next beat so it is already stable
          // when memory looks at it, and it holds through ack gaps.
          if (resp_i) begin
            if (count == last_beat) begin
              count   <= '0;
              burst_o <= '0;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state   <= DONE;
            end else begin
              burst_o <= wr_line[(int'(count) + 1) * s_burst +: s_burst];
              count   <= count + 1'b1;
            end
          end
        end

        DONE: begin
          resp_o <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Responder for the cache's physical-memory line interface: accepts one 256-bit line read or write per request and answers with a single-cycle response.
- Converts each request into a 4-beat, 64-bit burst toward main memory.
- Sits between the cache's pmem_* port and the burst memory.
- Line-side ports mirror the cache's pmem_* signals in the opposite direction.

Parameters:
s_offset  5    byte-offset bits of a line; address_o low s_offset bits forced to 0
s_line    256  line width in bits
s_burst   64   burst beat width in bits; beats = s_line/s_burst = 4

Ports:
clk        input   1       clock; all state updates on rising edge
rst        input   1       synchronous, active-high reset
address_i  input   32      line request address (cache pmem_address)
line_i     input   256     write line data (cache pmem_wdata)
line_o     output  256     read line data (to cache pmem_rdata)
read_i     input   1       line read request
write_i    input   1       line write request
resp_o     output  1       one-cycle completion pulse (to cache pmem_resp)
address_o  output  32      burst address, line-aligned
burst_i    input   64      read beat data from memory
burst_o    output  64      write beat data to memory
read_o     output  1       burst read request
write_o    output  1       burst write request
resp_i     input   1       per-beat acknowledge from memory

Behaviour:
- Reset: one clock and a synchronous, active-high reset are fixed. With rst high at a rising edge:
  - state = IDLE, beat counter = 0.
  - line_o, address_o, burst_o = 0.
  - read_o, write_o, resp_o = 0.
  - A rst mid-burst aborts the burst with no resp_o; the memory side sees read_o/write_o drop the next cycle.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - read_i=1: latch {address_i[31:s_offset], 0}, go to READ.
  - else write_i=1: latch the address and line_i, go to WRITE.
  - If read_i and write_i are both 1, read wins; write_i is ignored.
  - resp_i in IDLE or DONE is ignored.
- READ:
  - read_o=1, address_o = latched address, counter c in 0..3.
  - Each cycle with resp_i=1: buffer[64c +: 64] <= burst_i; c <= c+1.
  - resp_i=0: hold state; gaps between beats are legal.
  - On the beat with c=3: line_o <= assembled line (including this beat), c <= 0, go to DONE; read_o drops in DONE.
- WRITE:
  - write_o=1, address_o = latched address, burst_o = latched_line[64c +: 64] (beat 0 = bits 63:0).
  - Each resp_i=1 advances c; the beat with c=3 goes to DONE.
- DONE:
  - resp_o=1 for exactly this one cycle; read_o=write_o=0; go to IDLE.
- Requester rules:
  - Requester holds read_i/write_i and address_i stable until it sees resp_o.
  - address_i and line_i changes after latching are ignored until the next IDLE.
  - A request held high in the cycle after resp_o is treated as a new request.
- line_o persists from one completed read until the next completed read; writes do not change it.
- Latency, request sampled in IDLE at edge t, zero-wait memory:
  - read_o/write_o high in cycles t+1..t+4.
  - Beats at t+1..t+4; resp_o at t+5.
  - Minimum 5 cycles request-to-resp; each resp_i gap adds one cycle.
- Beat counter is 2 bits and wraps 3->0 only on the final beat; no other wrap.

Test Plan:
- Read, zero-wait: address_i=0x1234_5678, burst_i beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp_i -> address_o=0x1234_5660; read_o high 4 cycles; resp_o one cycle later; line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write with stalls: line_i = {0xDDDD.., 0xCCCC.., 0xBBBB.., 0xAAAA..}, resp_i pattern 1,0,0,1,1,0,1 -> burst_o shows AA.., BB.., CC.., DD.. in order; each beat held through gaps; resp_o in the cycle after the 4th acknowledge; write_o never high with read_o.
- Simultaneous request: read_i=write_i=1 in IDLE -> only read_o asserts; line_o updated; no write beats.
- Reset mid-read: assert rst after 2 beats -> next cycle read_o=0, resp_o=0, line_o=0. A following read completes normally with fresh data; no stale beats.
- Back-to-back: read_i held through resp_o and one more cycle -> second read_o burst begins the cycle after the return to IDLE; two resp_o pulses separated by ≥5 cycles.
- Stray ack: resp_i=1 in IDLE and DONE -> no state change, no resp_o, line_o unchanged.
